sfm_streamer_strb_gen_2d: RTL and testbench

Byte-strobe generator for the SoftEx streamer, the successor of the single-dimension leftover strobe generator. It sits between the HCI streamer data path and the memory-side sink/source stream. It masks both leading bytes (unaligned base address) and trailing bytes (row length not a multiple of the bus width) on every row of a 2D transfer. It also tracks beats and rows itself and reports busy/done.

---
 rtl/sfm_streamer_strb_gen_2d.sv | 191 +++++++++++++++++++
 tb/tb_sfm_streamer_strb_gen_2d.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfm_streamer_strb_gen_2d.sv
// Byte-strobe generator for the SoftEx streamer (2D variant).
//
// Sits between the HCI streamer data path and the memory-side stream. Data,
// valid and ready pass through with zero latency while the block is running.
// The block generates a byte strobe that masks:
//   - leading bytes of the first beat of every row (unaligned base address);
//   - trailing bytes of the last beat of every row (row length not a multiple
//     of the bus width).
// It also counts beats and rows itself and reports busy/done.
//
// The stream_i sink and the stream_o source are flattened into plain ports:
//   stream_i : in_data_i, in_valid_i, in_ready_o
//   stream_o : out_data_o, out_strb_o, out_valid_o, out_ready_i
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   clear_i      synchronous soft clear, same effect as rst_i
//   start_i      one-cycle pulse, latches config and starts a transfer
//   base_addr_i  transfer base byte address (only the in-beat offset is used)
//   d0_len_i     bytes per row
//   d1_len_i     number of rows
//   busy_o       high while the transfer is running or in its done cycle
//   done_o       one-cycle pulse after the last beat handshake
module sfm_streamer_strb_gen_2d #(
    parameter int unsigned DW    = 128,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   base_addr_i,
    input  logic [CNT_W-1:0]   d0_len_i,
    input  logic [CNT_W-1:0]   d1_len_i,
    output logic               busy_o,
    output logic               done_o,
    // stream_i (sink)
    input  logic [DW-1:0]      in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    // stream_o (source)
    output logic [DW-1:0]      out_data_o,
    output logic [DW/8-1:0]    out_strb_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    localparam int unsigned NB    = DW / 8;
    // NB must be at least 2 so the offset field has a non-zero width.
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;

    // Latched configuration. The beat and row limits are stored as "last index"
    // values so the per-beat comparisons need no arithmetic.
    logic [OFF_W-1:0]   off_q, off_d;
    logic [OFF_W-1:0]   end_b_q, end_b_d;
    logic [CNT_W-1:0]   beat_last_q, beat_last_d;
    logic [CNT_W-1:0]   row_last_q, row_last_d;

    logic               running;
    logic               hs;
    logic               first_beat;
    logic               last_beat;
    logic               last_row;

    // Start-time configuration decode.
    logic [OFF_W-1:0]   off_in;
    logic [CNT_W:0]     bpr_in;
    logic [OFF_W-1:0]   end_b_in;
    logic               empty_in;

    // Upper address bits are don't-care: rows are stride-aligned to the bus.
    logic               unused_base;
    assign unused_base = ^base_addr_i[CNT_W-1:OFF_W];

    assign off_in   = base_addr_i[OFF_W-1:0];
    // Computed one bit wider than CNT_W so off + len + NB - 1 cannot overflow.
    assign bpr_in   = ({1'b0, d0_len_i} + {{(CNT_W+1-OFF_W){1'b0}}, off_in}
                       + (CNT_W+1)'(NB - 1)) >> OFF_W;
    // Only the low bits matter for (off + len - 1) mod NB.
    assign end_b_in = off_in + d0_len_i[OFF_W-1:0] - OFF_W'(1);
    assign empty_in = (d0_len_i == '0) || (d1_len_i == '0);

    // Zero-latency data path, gated by the RUN state.
    assign running     = (state_q == StRun);
    assign out_data_o  = in_data_i;
    assign out_valid_o = in_valid_i & running;
    assign in_ready_o  = out_ready_i & running;
    assign hs          = in_valid_i & in_ready_o;

    assign first_beat  = (beat_cnt_q == '0);
    assign last_beat   = (beat_cnt_q == beat_last_q);
    assign last_row    = (row_cnt_q == row_last_q);

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);

    // Strobe: leading mask on the first beat, trailing mask on the last beat,
    // both on a single-beat row, all ones in between.
    always_comb begin
        out_strb_o = '0;
        if (running) begin
            for (int unsigned i = 0; i < NB; i++) begin
                out_strb_o[i] = 1'b1;
                if (first_beat && (OFF_W'(i) < off_q)) begin
                    out_strb_o[i] = 1'b0;
                end
                if (last_beat && (OFF_W'(i) > end_b_q)) begin
                    out_strb_o[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        row_cnt_d   = row_cnt_q;
        off_d       = off_q;
        end_b_d     = end_b_q;
        beat_last_d = beat_last_q;
        row_last_d  = row_last_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    off_d       = off_in;
                    end_b_d     = end_b_in;
                    // bpr_in >= 1 whenever len != 0, and bpr_in - 1 fits in CNT_W.
                    beat_last_d = CNT_W'(bpr_in - (CNT_W+1)'(1));
                    row_last_d  = d1_len_i - CNT_W'(1);
                    beat_cnt_d  = '0;
                    row_cnt_d   = '0;
                    state_d     = empty_in ? StDone : StRun;
                end
            end
            StRun: begin
                if (hs) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        row_cnt_d  = row_cnt_q + CNT_W'(1);
                        if (last_row) begin
                            state_d = StDone;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                // start_i here is deliberately dropped.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Clear has priority over handshakes and start in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            row_cnt_q   <= '0;
            off_q       <= '0;
            end_b_q     <= '0;
            beat_last_q <= '0;
            row_last_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            row_cnt_q   <= row_cnt_d;
            off_q       <= off_d;
            end_b_q     <= end_b_d;
            beat_last_q <= beat_last_d;
            row_last_q  <= row_last_d;
        end
    end

endmodule

// File: tb/tb_sfm_streamer_strb_gen_2d.sv
// Self-checking bench for sfm_streamer_strb_gen_2d with a 16-byte bus.
// Expected strobes are computed from the transfer parameters and queued when
// a transfer is started; they are popped and compared on every handshake.
module tb_sfm_streamer_strb_gen_2d;

    localparam int unsigned DW    = 128;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned NB    = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              start;
    logic [CNT_W-1:0]  base_addr;
    logic [CNT_W-1:0]  d0_len;
    logic [CNT_W-1:0]  d1_len;
    logic              busy;
    logic              done;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic [NB-1:0]     out_strb;
    logic              out_valid;
    logic              out_ready;

    logic [NB-1:0]     exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    sfm_streamer_strb_gen_2d #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .start_i     (start),
        .base_addr_i (base_addr),
        .d0_len_i    (d0_len),
        .d1_len_i    (d1_len),
        .busy_o      (busy),
        .done_o      (done),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one mask per beat, rows repeat the same masks.
    task automatic push_expected(input logic [CNT_W-1:0] base, input int len, input int rows);
        int off;
        int span;
        int bpr;
        int endb;
        logic [NB-1:0] m;
        off = int'(base[3:0]);
        if (len == 0 || rows == 0) return;
        span = off + len;
        bpr  = (span + 15) / 16;
        endb = (span - 1) % 16;
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < bpr; b++) begin
                for (int i = 0; i < 16; i++) begin
                    m[i] = !((b == 0 && i < off) || (b == bpr - 1 && i > endb));
                end
                exp_q.push_back(m);
            end
        end
    endtask

    // restart_at: beat index at which a stray start is pulsed (-1 = never).
    // clear_at:   beat index at which clear is pulsed (-1 = never).
    task automatic run_xfer(input logic [CNT_W-1:0] base, input int len, input int rows,
                            input bit bp, input int restart_at, input int clear_at);
        int  hs_cnt;
        int  cyc;
        bit  cleared;
        bit  do_clear;
        exp_q.delete();
        push_expected(base, len, rows);

        @(posedge clk); #1;
        base_addr = base;
        d0_len    = CNT_W'(len);
        d1_len    = CNT_W'(rows);
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        // Scramble inputs: the DUT must be working from latched config.
        base_addr = 32'h9;
        d0_len    = 32'd7;
        d1_len    = 32'd5;

        if (exp_q.size() == 0) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            start     = 1'b1;  // lands on the DONE->IDLE cycle, must be dropped
            @(negedge clk);
            check_eq("empty_done", DW'(done), DW'(1'b1));
            check_eq("empty_busy", DW'(busy), DW'(1'b1));
            check_eq("empty_ready", DW'(in_ready), DW'(1'b0));
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check_eq("empty_done_low", DW'(done), DW'(1'b0));
            check_eq("empty_busy_low", DW'(busy), DW'(1'b0));
            return;
        end

        hs_cnt  = 0;
        cyc     = 0;
        cleared = 1'b0;
        while (exp_q.size() > 0 && cyc < 1000 && !cleared) begin
            in_valid  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            do_clear  = (hs_cnt == clear_at);
            clear     = do_clear;
            if (hs_cnt == restart_at) begin
                start     = 1'b1;
                base_addr = 32'h5;
                d0_len    = 32'd3;
                d1_len    = 32'd1;
            end
            @(negedge clk);
            check_eq("run_busy", DW'(busy), DW'(1'b1));
            check_eq("run_done", DW'(done), DW'(1'b0));
            check_eq("run_ready", DW'(in_ready), DW'(out_ready));
            check_eq("run_valid", DW'(out_valid), DW'(in_valid));
            if (!do_clear && in_valid && out_ready) begin
                check_eq("strb", DW'(out_strb), DW'(exp_q.pop_front()));
                check_eq("data", out_data, in_data);
                hs_cnt++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            clear = 1'b0;
            if (do_clear) cleared = 1'b1;
            cyc++;
        end

        if (cleared) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            exp_q.delete();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check_eq("clr_busy", DW'(busy), DW'(1'b0));
                check_eq("clr_done", DW'(done), DW'(1'b0));
                check_eq("clr_strb", DW'(out_strb), DW'(0));
                check_eq("clr_ready", DW'(in_ready), DW'(1'b0));
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            return;
        end

        check_eq("beats_left", DW'(exp_q.size()), DW'(0));
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", DW'(done), DW'(1'b1));
        check_eq("done_busy", DW'(busy), DW'(1'b1));
        check_eq("done_strb", DW'(out_strb), DW'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("done_low", DW'(done), DW'(1'b0));
        check_eq("idle_busy", DW'(busy), DW'(1'b0));
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        d0_len    = '0;
        d1_len    = '0;
        in_data   = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", DW'(busy), DW'(1'b0));
        check_eq("rst_done", DW'(done), DW'(1'b0));
        check_eq("rst_strb", DW'(out_strb), DW'(0));
        check_eq("rst_ready", DW'(in_ready), DW'(1'b0));
        check_eq("rst_valid", DW'(out_valid), DW'(1'b0));
        in_valid = 1'b0;

        run_xfer(32'h0,   64,  1, 1'b0,  2, -1);  // stray start while busy
        run_xfer(32'h0,   20,  1, 1'b0, -1, -1);
        run_xfer(32'h104,  8,  3, 1'b0, -1, -1);
        run_xfer(32'hC,   40,  2, 1'b0, -1, -1);
        run_xfer(32'hC,   40,  2, 1'b1, -1, -1);
        run_xfer(32'h0,    0,  3, 1'b0, -1, -1);
        run_xfer(32'h4,   16,  0, 1'b0, -1, -1);
        run_xfer(32'h0,   64,  1, 1'b0, -1,  2);  // clear after beat 2
        run_xfer(32'hC,   40,  2, 1'b0, -1, -1);
        run_xfer(32'h7,  100,  3, 1'b1, -1, -1);
        run_xfer(32'hF,    1,  2, 1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
